// File: rtl/fetch_align_stage.sv
// Fetch stage: word reads into a halfword buffer; one aligned 16/32-bit instruction per cycle to decode.
// Registered outputs, so the first f_valid comes 2 cycles after the first imem_ready; stall freezes outputs.
module fetch_align_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DEPTH        = 8,
  parameter logic [3:0]  ECAUSE_FAULT = 4'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        imem_error,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_exception,
  output logic [3:0]  f_ecause,
  output logic [31:0] f_etval
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH - 2);

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;
  state_t state_q, state_d;

  logic [15:0] buf_hw  [DEPTH];
  logic [31:0] buf_pc  [DEPTH];
  logic        buf_err [DEPTH];

  logic [PW-1:0] wptr_q, rptr_q, count;
  logic [AW-1:0] r0, r1, w0, w1;
  logic [31:0]   fetch_addr_q, drop_addr_q;
  logic          skip_q;
  logic          empty, h1_vld;
  logic [1:0]    pop_n, push_n;
  logic          push_fire, credit_ok;
  logic [OW-1:0] occ_nxt;
  logic          unused_pc_bit0;

  logic        al_vld, al_exc;
  logic [31:0] al_pc, al_instr, al_etval;

  assign unused_pc_bit0 = redirect_pc[0];

  assign empty  = (wptr_q == rptr_q);
  assign count  = wptr_q - rptr_q;
  assign h1_vld = (count >= PW'(2));
  assign r0     = rptr_q[AW-1:0];
  assign r1     = r0 + AW'(1);
  assign w0     = wptr_q[AW-1:0];
  assign w1     = w0 + AW'(1);

  always_comb begin
    al_vld   = 1'b0;
    al_exc   = 1'b0;
    al_instr = 32'h0;
    al_etval = 32'h0;
    al_pc    = buf_pc[r0];
    pop_n    = 2'd0;
    if (!empty) begin
      if (buf_err[r0]) begin
        al_vld   = 1'b1;
        al_exc   = 1'b1;
        al_etval = buf_pc[r0];
        pop_n    = 2'd1;
      end else if (buf_hw[r0][1:0] != 2'b11) begin
        al_vld   = 1'b1;
        al_instr = {16'h0, buf_hw[r0]};
        pop_n    = 2'd1;
      end else if (h1_vld) begin
        al_vld   = 1'b1;
        al_instr = {buf_hw[r1], buf_hw[r0]};
        al_exc   = buf_err[r1];
        al_etval = buf_err[r1] ? buf_pc[r1] : 32'h0;
        pop_n    = 2'd2;
      end
    end
    if (stall || redirect) pop_n = 2'd0;
  end

  // A response arriving in a redirect cycle belongs to the old stream and is never pushed.
  assign push_fire = (state_q == BUSY) && imem_ready && !redirect;
  assign push_n    = push_fire ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
  assign occ_nxt   = OW'(count) + OW'(push_n) - OW'(pop_n);
  assign credit_ok = (occ_nxt <= OCC_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!redirect && credit_ok) state_d = BUSY;
      BUSY: begin
        if (redirect)        state_d = imem_ready ? IDLE : DROP;
        else if (imem_ready) state_d = credit_ok ? BUSY : IDLE;
      end
      DROP: if (imem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign imem_valid = (state_q != IDLE);
  assign imem_addr  = (state_q == DROP) ? drop_addr_q : fetch_addr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      drop_addr_q  <= {RESET_PC[31:2], 2'b00};
      skip_q       <= RESET_PC[1];
    end else begin
      state_q <= state_d;
      if (redirect) begin
        wptr_q       <= '0;
        rptr_q       <= '0;
        fetch_addr_q <= {redirect_pc[31:2], 2'b00};
        skip_q       <= redirect_pc[1];
        if (state_q == BUSY) drop_addr_q <= fetch_addr_q;
      end else begin
        rptr_q <= rptr_q + PW'(pop_n);
        wptr_q <= wptr_q + PW'(push_n);
        if (push_fire) begin
          fetch_addr_q <= fetch_addr_q + 32'd4;
          skip_q       <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_fire) begin
      if (skip_q) begin
        buf_hw[w0]  <= imem_rdata[31:16];
        buf_pc[w0]  <= fetch_addr_q + 32'd2;
        buf_err[w0] <= imem_error;
      end else begin
        buf_hw[w0]  <= imem_rdata[15:0];
        buf_pc[w0]  <= fetch_addr_q;
        buf_err[w0] <= imem_error;
        buf_hw[w1]  <= imem_rdata[31:16];
        buf_pc[w1]  <= fetch_addr_q + 32'd2;
        buf_err[w1] <= imem_error;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      f_valid     <= 1'b0;
      f_pc        <= RESET_PC;
      f_instr     <= 32'h0;
      f_exception <= 1'b0;
      f_ecause    <= 4'h0;
      f_etval     <= 32'h0;
    end else if (redirect) begin
      f_valid <= 1'b0;
    end else if (!stall) begin
      f_valid <= al_vld;
      if (al_vld) begin
        f_pc        <= al_pc;
        f_instr     <= al_instr;
        f_exception <= al_exc;
        f_ecause    <= al_exc ? ECAUSE_FAULT : 4'h0;
        f_etval     <= al_etval;
      end
    end
  end
endmodule
